seq_booth_multiplier: RTL and testbench

Iterative radix-2 Booth multiplier for the FC datapath, generalised to N-bit operands.
Supports signed and unsigned operands, selected per transaction.
Processes one Booth step per clock and uses valid/ready handshakes on both input and output, so it can sit between the weight/activation buffers and the accumulator.
Replaces the combinational multiplier where timing closure at larger N requires a multi-cycle unit.

---
 rtl/fc_mul_pkg.sv | 23 ++
 rtl/booth_step.sv | 30 +++
 rtl/seq_booth_multiplier.sv | 136 +++++++++++++
 tb/tb_seq_booth_multiplier.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_mul_pkg.sv
// Shared definitions for the FC-datapath sequential Booth multiplier.
//   mul_state_e   : controller states (idle / running Booth steps / result held)
//   BOOTH_*       : decode of the Booth pair P[1:0]
//   booth_width() : internal operand width W = N + 1 (room for sign/zero extension)
package fc_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mul_state_e;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  // One extra bit lets unsigned operands be treated as non-negative signed values.
  function automatic int unsigned booth_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// Single combinational radix-2 Booth step: conditional add of A or S selected by
// the Booth pair P[1:0], followed by a 1-bit arithmetic right shift.
//   p_i : current partial-product register (PW bits)
//   a_i : {+M, zeros}, s_i : {-M, zeros}
//   p_o : next partial-product value
// The add wraps modulo 2^PW.
module booth_step
  import fc_mul_pkg::*;
#(
  parameter int unsigned PW = 19
) (
  input  logic [PW-1:0] p_i,
  input  logic [PW-1:0] a_i,
  input  logic [PW-1:0] s_i,
  output logic [PW-1:0] p_o
);

  logic [PW-1:0] sum;

  always_comb begin
    sum = p_i;
    unique case (p_i[1:0])
      BOOTH_ADD:              sum = p_i + a_i;
      BOOTH_SUB:              sum = p_i + s_i;
      BOOTH_NOP0, BOOTH_NOP1: sum = p_i;
    endcase
    p_o = {sum[PW-1], sum[PW-1:1]};
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock, valid/ready on
// both sides. Signed or unsigned operands selected per transaction.
//   clk, rst_n          : clock, asynchronous active-low reset
//   inValid / inReady   : operand handshake (M, R, isSigned sampled on accept)
//   outValid / outReady : result handshake; mulResult held while stalled
//   mulResult           : 2N-bit product
// Optional macro BOOTH_EARLY_TERM_EN: when the unscanned multiplier bits and the
// Booth bit are uniform, the remaining steps collapse into one shift.
module seq_booth_multiplier
  import fc_mul_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inValid,
  output logic           inReady,
  input  logic           isSigned,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   R,
  output logic           outValid,
  input  logic           outReady,
  output logic [2*N-1:0] mulResult
);

  localparam int unsigned CNT_W = $clog2(N + 2);
  localparam int unsigned W     = booth_width(N);
  localparam int unsigned PW    = 2 * W + 1;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(W - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [W-1:0]     m_q, m_d;
  logic [2*N-1:0]   result_q, result_d;

  logic [W-1:0]  m_ext, r_ext, m_neg;
  logic [PW-1:0] a_val, s_val, p_step;

  assign m_ext = isSigned ? {M[N-1], M} : {1'b0, M};
  assign r_ext = isSigned ? {R[N-1], R} : {1'b0, R};
  assign m_neg = ~m_q + 1'b1;
  assign a_val = {m_q, {(W + 1){1'b0}}};
  assign s_val = {m_neg, {(W + 1){1'b0}}};

  booth_step #(
    .PW (PW)
  ) u_booth_step (
    .p_i (p_q),
    .a_i (a_val),
    .s_i (s_val),
    .p_o (p_step)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // After cnt_q steps the unscanned multiplier bits plus the Booth bit sit in
  // P[W-cnt_q:0]; if they are uniform every remaining step is a pure shift.
  logic [W:0]       scan_mask, scan_bits;
  logic [CNT_W-1:0] remain;
  logic             early_hit;
  logic [PW-1:0]    p_early;

  assign scan_mask = {(W + 1){1'b1}} >> cnt_q;
  assign scan_bits = p_q[W:0] & scan_mask;
  assign early_hit = (scan_bits == '0) || (scan_bits == scan_mask);
  assign remain    = CNT_W'(W) - cnt_q;
  assign p_early   = $signed(p_q) >>> remain;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    m_d      = m_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (inValid) begin
          m_d     = m_ext;
          p_d     = {{W{1'b0}}, r_ext, 1'b0};
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
`ifdef BOOTH_EARLY_TERM_EN
        if (early_hit) begin
          p_d      = p_early;
          result_d = p_early[2*N:1];
          state_d  = StDone;
        end else begin
          p_d   = p_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            result_d = p_step[2*N:1];
            state_d  = StDone;
          end
        end
`else
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = p_step[2*N:1];
          state_d  = StDone;
        end
`endif
      end
      StDone: begin
        if (outReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign inReady   = (state_q == StIdle);
  assign outValid  = (state_q == StDone);
  assign mulResult = result_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
module tb_seq_booth_multiplier;

  localparam int unsigned N = 8;
  localparam int ExpLat = N + 1;

  logic           clk;
  logic           rst_n;
  logic           inValid;
  logic           inReady;
  logic           isSigned;
  logic [N-1:0]   M;
  logic [N-1:0]   R;
  logic           outValid;
  logic           outReady;
  logic [2*N-1:0] mulResult;

  int checks;
  int failures;

  seq_booth_multiplier #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .isSigned  (isSigned),
    .M         (M),
    .R         (R),
    .outValid  (outValid),
    .outReady  (outReady),
    .mulResult (mulResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one transaction, returns the observed result and the number of edges
  // from accept to outValid (capped at 40). Holds outReady low for `stall` cycles.
  task automatic do_op(input logic s, input logic [N-1:0] m, input logic [N-1:0] r,
                       input int stall, output logic [2*N-1:0] res, output int lat);
    @(negedge clk);
    outReady = (stall == 0);
    inValid  = 1'b1;
    isSigned = s;
    M        = m;
    R        = r;
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    M        = N'($urandom);
    R        = N'($urandom);
    isSigned = 1'($urandom);
    lat = 0;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = mulResult;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      @(negedge clk);
      outReady = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic lat_ok(input int lat);
`ifdef BOOTH_EARLY_TERM_EN
    return (lat >= 1) && (lat <= ExpLat);
`else
    return lat == ExpLat;
`endif
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    inValid  = 1'b0;
    isSigned = 1'b0;
    M        = '0;
    R        = '0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_inReady got=%b want=1", inReady);
    end
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outValid got=%b want=0", outValid);
    end
    checks++;
    if (mulResult !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mulResult got=%h want=0000", mulResult);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signed_basic();
    logic [2*N-1:0] res;
    int lat;
    do_op(1'b1, 8'hFD, 8'h05, 0, res, lat);
    checks++;
    if (res !== 16'hFFF1) begin
      failures++;
      $display("FAIL signed_m3x5 got=%h want=fff1", res);
    end
    checks++;
    if (!lat_ok(lat)) begin
      failures++;
      $display("FAIL signed_m3x5_latency got=%0d want=%0d", lat, ExpLat);
    end
  endtask

  task automatic test_boundaries();
    logic [N-1:0]   vm[9] = '{8'hFF, 8'h80, 8'h00, 8'h55, 8'h7F, 8'h80, 8'hFF, 8'h12, 8'h07};
    logic [N-1:0]   vr[9] = '{8'hFF, 8'h80, 8'hAB, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h34, 8'h06};
    logic           vs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2*N-1:0] ve[9] = '{16'hFE01, 16'h4000, 16'h0000, 16'h0000, 16'hC080,
                              16'h7F80, 16'h0001, 16'h03A8, 16'h002A};
    logic [2*N-1:0] res;
    int lat;
    for (int i = 0; i < 9; i++) begin
      do_op(vs[i], vm[i], vr[i], 0, res, lat);
      checks++;
      if (res !== ve[i]) begin
        failures++;
        $display("FAIL boundary_%0d s=%b m=%h r=%h got=%h want=%h",
                 i, vs[i], vm[i], vr[i], res, ve[i]);
      end
      checks++;
      if (!lat_ok(lat)) begin
        failures++;
        $display("FAIL boundary_%0d_latency got=%0d want=%0d", i, lat, ExpLat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    outReady = 1'b0;
    inValid  = 1'b1;
    isSigned = 1'b0;
    M        = 8'd3;
    R        = 8'd4;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!outValid) begin
      failures++;
      $display("FAIL backpressure_outValid_timeout got=0 want=1");
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      inValid = c[0];
      M       = 8'hAA;
      R       = 8'h55;
      @(posedge clk);
      #1;
      checks++;
      if (mulResult !== 16'd12 || outValid !== 1'b1 || inReady !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold_%0d got res=%h ov=%b ir=%b want res=000c ov=1 ir=0",
                 c, mulResult, outValid, inReady);
      end
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got ir=%b ov=%b want ir=1 ov=0", inReady, outValid);
    end
  endtask

  task automatic test_reset_abort();
    logic [2*N-1:0] res;
    int lat;
    int seen;
    @(negedge clk);
    outReady = 1'b1;
    inValid  = 1'b1;
    isSigned = 1'b1;
    M        = 8'h09;
    R        = 8'h09;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      failures++;
      $display("FAIL abort_async got ov=%b ir=%b want ov=0 ir=1", outValid, inReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (outValid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_outValid got=%0d pulses want=0", seen);
    end
    do_op(1'b0, 8'd7, 8'd6, 0, res, lat);
    checks++;
    if (res !== 16'd42) begin
      failures++;
      $display("FAIL abort_next_7x6 got=%h want=002a", res);
    end
    checks++;
    if (!lat_ok(lat)) begin
      failures++;
      $display("FAIL abort_next_latency got=%0d want=%0d", lat, ExpLat);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   m, r;
    logic           s;
    logic [2*N-1:0] me, re, exp_p, res;
    int lat;
    for (int i = 0; i < 300; i++) begin
      m  = N'($urandom);
      r  = N'($urandom);
      s  = 1'($urandom);
      me = s ? {{N{m[N-1]}}, m} : {{N{1'b0}}, m};
      re = s ? {{N{r[N-1]}}, r} : {{N{1'b0}}, r};
      exp_p = me * re;
      do_op(s, m, r, int'($urandom_range(0, 3)), res, lat);
      checks++;
      if (res !== exp_p || !lat_ok(lat)) begin
        failures++;
        $display("FAIL random_%0d s=%b m=%h r=%h got=%h lat=%0d want=%h lat=%0d",
                 i, s, m, r, res, lat, exp_p, ExpLat);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_signed_basic();
    test_boundaries();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
